// File: rtl/pb_bit_writer.sv
// Two debounced pushbuttons walk a cursor over a WIDTH-bit register; wr stores din at the cursor.
// Pin-to-cursor latency 3+DEBOUNCE_CYCLES clk, wr-to-out 1 clk; no backpressure, every cycle is accepted.
module pb_bit_writer #(
    parameter int WIDTH           = 16,
    parameter int IDX_W           = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pb,
    input  logic             din,
    input  logic             wr,
    output logic [WIDTH-1:0] out,
    output logic [IDX_W-1:0] cursor
);
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_press;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_diff;
    logic [1:0]       w_accept;
    logic [WIDTH-1:0] r_out;
    logic [IDX_W-1:0] r_cursor;
    logic [IDX_W-1:0] w_cursor_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= pb;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_diff   = r_sync2 ^ r_deb;
        w_accept = '0;
        for (int i = 0; i < 2; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // A press event is the registered acceptance of a falling debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb    <= 2'b11;
            r_press  <= 2'b00;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_diff[i] && !w_accept[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= '0;
                end
                if (w_accept[i]) begin
                    r_deb[i] <= r_sync2[i];
                end
                r_press[i] <= w_accept[i] & ~r_sync2[i];
            end
        end
    end

    always_comb begin
        w_cursor_nxt = r_cursor;
        if (r_deb == 2'b00) begin
            w_cursor_nxt = IDX_LAST;
        end else if (r_press[0] && r_deb[1]) begin
            if (r_cursor != '0) begin
                w_cursor_nxt = r_cursor - IDX_W'(1);
            end
        end else if (r_press[1] && r_deb[0]) begin
            if (r_cursor != IDX_LAST) begin
                w_cursor_nxt = r_cursor + IDX_W'(1);
            end
        end
    end

    // The write uses the pre-update cursor, so a same-cycle move does not redirect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cursor <= IDX_LAST;
            r_out    <= '0;
        end else begin
            r_cursor <= w_cursor_nxt;
            if (wr) begin
                r_out[r_cursor] <= din;
            end
        end
    end

    assign out    = r_out;
    assign cursor = r_cursor;

endmodule

// File: tb/tb_pb_bit_writer.sv
// Bench for pb_bit_writer: every register change is predicted when stimulus is driven and
// matched in order (value and arrival cycle) by a negedge monitor.
module tb_pb_bit_writer;
    localparam int WIDTH = 16;
    localparam int IDX_W = 4;
    localparam int DEB   = 4;
    localparam int LAT   = 3 + DEB;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       pb    = 2'b11;
    logic             din   = 1'b0;
    logic             wr    = 1'b0;
    logic [WIDTH-1:0] out;
    logic [IDX_W-1:0] cursor;

    always #5 clk = ~clk;

    pb_bit_writer #(
        .WIDTH          (WIDTH),
        .IDX_W          (IDX_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pb    (pb),
        .din   (din),
        .wr    (wr),
        .out   (out),
        .cursor(cursor)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [IDX_W-1:0] cur;
        logic [WIDTH-1:0] val;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic [IDX_W-1:0] m_cur;
    logic [WIDTH-1:0] m_out;
    bit               mon_en = 1'b0;
    logic [IDX_W-1:0] p_cur;
    logic [WIDTH-1:0] p_out;

    // at_cyc < 0 means the arrival cycle is not checked (asynchronous reset).
    task automatic expect_change(input int at_cyc);
        exp_t e;
        e.cur = m_cur;
        e.val = m_out;
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && (cursor !== p_cur || out !== p_out)) begin
            if (sb.size() == 0) begin
                check("unexpected_cursor", cursor, p_cur);
                check("unexpected_out", out, p_out);
            end else begin
                e = sb.pop_front();
                check("sb_cursor", cursor, e.cur);
                check("sb_out", out, e.val);
                if (e.cyc >= 0) check("sb_latency", cyc, e.cyc);
            end
            p_cur = cursor;
            p_out = out;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int btn, input int low_cycles);
        @(posedge clk);
        #1;
        pb[btn] = 1'b0;
        if (low_cycles >= DEB) begin
            if (btn == 0 && m_cur != 0) begin
                m_cur = m_cur - 1'b1;
                expect_change(cyc + LAT);
            end else if (btn == 1 && m_cur != WIDTH - 1) begin
                m_cur = m_cur + 1'b1;
                expect_change(cyc + LAT);
            end
        end
        wait_cycles(low_cycles);
        pb[btn] = 1'b1;
        wait_cycles(DEB + 8);
    endtask

    task automatic write_bit(input logic d);
        @(posedge clk);
        #1;
        wr  = 1'b1;
        din = d;
        if (m_out[m_cur] !== d) begin
            m_out[m_cur] = d;
            expect_change(cyc + 1);
        end
        wait_cycles(1);
        wr = 1'b0;
    endtask

    initial begin
        m_cur = IDX_W'(WIDTH - 1);
        m_out = '0;
        #12;
        check("reset_cursor", cursor, 15);
        check("reset_out", out, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        p_cur  = cursor;
        p_out  = out;
        mon_en = 1'b1;

        // single write at the reset cursor
        write_bit(1'b1);
        check("t1_out", out, 16'h8000);
        check("t1_cursor", cursor, 15);

        // three decrements, then write at 12
        repeat (3) press(0, 10);
        check("t2_cursor", cursor, 12);
        write_bit(1'b1);
        check("t2_out", out, 16'h9000);

        // saturation at both ends
        repeat (3) press(1, 10);
        check("t3_top", cursor, 15);
        repeat (2) press(1, 10);
        check("t3_top_sat", cursor, 15);
        repeat (15) press(0, 10);
        check("t3_bottom", cursor, 0);
        press(0, 10);
        check("t3_bottom_sat", cursor, 0);
        write_bit(1'b1);
        check("t3_bit0", out[0], 1);

        // glitch rejection versus a just-long-enough press
        press(1, 10);
        press(0, DEB - 1);
        check("t4_glitch", cursor, 1);
        press(0, DEB);
        check("t4_min_press", cursor, 0);

        // both buttons
        repeat (5) press(1, 10);
        check("t5_start", cursor, 5);
        @(posedge clk);
        #1;
        pb    = 2'b00;
        m_cur = IDX_W'(WIDTH - 1);
        expect_change(cyc + LAT);
        wait_cycles(20);
        check("t5_both_hold", cursor, 15);
        pb[1] = 1'b1;
        wait_cycles(12);
        pb[0] = 1'b1;
        wait_cycles(12);
        check("t5_release", cursor, 15);
        pb[0] = 1'b0;
        m_cur = m_cur - 1'b1;
        expect_change(cyc + LAT);
        wait_cycles(12);
        pb[1] = 1'b0;
        m_cur = IDX_W'(WIDTH - 1);
        expect_change(cyc + LAT);
        wait_cycles(12);
        check("t5_inc_while_held", cursor, 15);
        pb = 2'b11;
        wait_cycles(12);

        // write on the same edge as an increment
        repeat (12) press(0, 10);
        check("t6_start", cursor, 3);
        din   = 1'b1;
        pb[1] = 1'b0;
        begin
            int t0;
            t0 = cyc;
            wait_cycles(DEB + 2);
            wr           = 1'b1;
            m_out[m_cur] = 1'b1;
            m_cur        = m_cur + 1'b1;
            expect_change(t0 + LAT);
        end
        wait_cycles(1);
        wr = 1'b0;
        check("t6_bit3", out[3], 1);
        check("t6_cursor", cursor, 4);

        // asynchronous reset while pb[1] is still held
        wait_cycles(2);
        #1;
        m_cur = IDX_W'(WIDTH - 1);
        m_out = '0;
        expect_change(-1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cursor", cursor, 15);
        check("t6_rst_out", out, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_cycles(DEB + 8);
        check("t6_post_rst_sat", cursor, 15);
        pb[1] = 1'b1;
        wait_cycles(12);

        // reset mid-debounce: the held button is re-qualified from scratch
        pb[0] = 1'b0;
        wait_cycles(3);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_cur = m_cur - 1'b1;
        expect_change(cyc + LAT);
        wait_cycles(12);
        pb[0] = 1'b1;
        wait_cycles(12);
        check("t6_requalify", cursor, 14);

        wait_cycles(10);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
